stack_engine: RTL and testbench

Parametrised signed stack calculator, successor to the basic push/pop/add/mul stack. It adds a valid/ready op handshake, SUB/DUP/SWAP opcodes, signed-overflow detection and an iterative multi-cycle multiplier. It sits behind the command decoder and is the sole owner of the operand stack.

---
 rtl/stack_pkg.sv | 26 ++
 rtl/stack_engine_if.sv | 25 ++
 rtl/seq_mult.sv | 51 +++++
 rtl/stack_engine.sv | 171 +++++++++++++++++
 tb/tb_stack_engine.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared types and helpers for the stack_engine operand-stack calculator.
package stack_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'b000,
    DUP  = 3'b001,
    SWAP = 3'b010,
    SUB  = 3'b011,
    ADD  = 3'b100,
    MUL  = 3'b101,
    PUSH = 3'b110,
    POP  = 3'b111
  } opcode_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

  // Signed add overflow from sign bits only: operands agree in sign but the
  // result does not. For subtraction pass the inverted sign of the subtrahend.
  function automatic logic add_ovf(input logic a, input logic b, input logic r);
    return (a == b) && (r != a);
  endfunction

endpackage

// File: rtl/stack_engine_if.sv
// Op handshake and result bus between the command decoder and stack_engine.
interface stack_engine_if #(
  parameter int WIDTH = 8
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] input_data;
  logic [WIDTH-1:0] output_data;
  logic             out_valid;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             err;

  modport master (
    output op_valid, opcode, input_data,
    input  op_ready, output_data, out_valid, empty, full, overflow, err
  );

  modport slave (
    input  op_valid, opcode, input_data,
    output op_ready, output_data, out_valid, empty, full, overflow, err
  );
endinterface

// File: rtl/seq_mult.sv
// Signed iterative shift-add multiplier; one multiplier bit per cycle.
// The top multiplier bit carries weight -2^(W-1), so its partial product is
// subtracted. done/product are presented combinationally during the final
// iteration so the consumer can capture the result on the same edge.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int NW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, acc_q, addend, acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [NW-1:0]      cnt_q;
  logic               busy_q, last;

  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign last      = busy_q && (cnt_q == NW'(WIDTH - 1));
  assign acc_next  = last ? (acc_q - addend) : (acc_q + addend);
  assign done_o    = last;
  assign product_o = acc_next;

  // Load operands on start, then accumulate one shifted partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{a_i[WIDTH-1]}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + NW'(1);
      if (last) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/stack_engine.sv
// Signed stack calculator: owns the operand stack, executes single-cycle ops
// in IDLE and hands MUL to seq_mult while op_ready is held low.
module stack_engine #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  stack_engine_if.slave  bus
);
  import stack_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [WIDTH-1:0] word_t;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  word_t              stack_q [DEPTH];
  word_t              stack_d [DEPTH];
  word_t              out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               empty_q, full_q;

  logic [IW-1:0]      top_idx, nxt_idx, push_idx;
  word_t              t_val, n_val, sum, diff;
  logic               has_one, has_two, is_full, accept;
  logic               mul_start, mul_done, mul_ovf;
  logic [2*WIDTH-1:0] mul_prod;
  opcode_e            op;

  assign top_idx  = IW'(count_q - CW'(1));
  assign nxt_idx  = IW'(count_q - CW'(2));
  assign push_idx = IW'(count_q);
  assign t_val    = stack_q[top_idx];
  assign n_val    = stack_q[nxt_idx];
  assign sum      = n_val + t_val;
  assign diff     = n_val - t_val;
  assign has_one  = count_q >= CW'(1);
  assign has_two  = count_q >= CW'(2);
  assign is_full  = count_q == CW'(DEPTH);
  assign accept   = bus.op_valid && ready_q;
  assign op       = opcode_e'(bus.opcode);
  assign mul_ovf  = mul_prod != {{WIDTH{mul_prod[WIDTH-1]}}, mul_prod[WIDTH-1:0]};

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (n_val),
    .b_i       (t_val),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Next-state decode: op execution, bounds rejection and MUL completion.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    stack_d     = stack_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    err_d       = 1'b0;
    ready_d     = ready_q;
    mul_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            NOP: ;
            DUP: begin
              if (has_one && !is_full) begin
                stack_d[push_idx] = t_val;
                count_d = count_q + CW'(1);
              end else err_d = 1'b1;
            end
            SWAP: begin
              if (has_two) begin
                stack_d[top_idx] = n_val;
                stack_d[nxt_idx] = t_val;
              end else err_d = 1'b1;
            end
            SUB, ADD: begin
              if (has_two) begin
                out_d = (op == ADD) ? sum : diff;
                ovf_d = (op == ADD) ? add_ovf(n_val[WIDTH-1], t_val[WIDTH-1], sum[WIDTH-1])
                                    : add_ovf(n_val[WIDTH-1], ~t_val[WIDTH-1], diff[WIDTH-1]);
                stack_d[nxt_idx] = out_d;
                count_d = count_q - CW'(1);
                out_valid_d = 1'b1;
              end else err_d = 1'b1;
            end
            MUL: begin
              if (has_two) begin
                mul_start = 1'b1;
                state_d   = MUL_RUN;
                ready_d   = 1'b0;
              end else err_d = 1'b1;
            end
            PUSH: begin
              if (!is_full) begin
                stack_d[push_idx] = bus.input_data;
                count_d = count_q + CW'(1);
              end else err_d = 1'b1;
            end
            POP: begin
              if (has_one) begin
                out_d = t_val;
                count_d = count_q - CW'(1);
                out_valid_d = 1'b1;
              end else err_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL_RUN: begin
        if (mul_done) begin
          out_d = mul_prod[WIDTH-1:0];
          ovf_d = mul_ovf;
          stack_d[nxt_idx] = out_d;
          count_d = count_q - CW'(1);
          out_valid_d = 1'b1;
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, stack storage and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      stack_q     <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stack_q     <= stack_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == CW'(DEPTH));
    end
  end

  assign bus.op_ready    = ready_q;
  assign bus.output_data = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.overflow    = ovf_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine with DEPTH=4, WIDTH=8.
module tb_stack_engine;
  import stack_pkg::*;

  logic clk;
  logic rst_n;
  int   assertCount = 0;
  int   failCount = 0;
  int   busyCycles;

  stack_engine_if #(.WIDTH(8)) bus ();

  stack_engine #(.DEPTH(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Present one op at the falling edge, hold it until accepted, then release
  // it one time unit after the accepting edge so results can be sampled.
  task automatic applyStimulus(input opcode_e op, input logic [7:0] data);
    int waitCycles;
    @(negedge clk);
    bus.op_valid   = 1'b1;
    bus.opcode     = op;
    bus.input_data = data;
    waitCycles = 0;
    while (!bus.op_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.op_ready) checkOutput("ready_timeout", 32'(bus.op_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.op_valid = 1'b0;
    bus.opcode = 3'b000;
    bus.input_data = 8'h00;
    #12;
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_out", 32'(bus.output_data), 32'h0);
    checkOutput("rst_outvalid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_ready", 32'(bus.op_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to capacity, overflow the stack, then drain and underflow.
    applyStimulus(PUSH, 8'd1);
    checkOutput("push1_empty", 32'(bus.empty), 32'd0);
    applyStimulus(PUSH, 8'd2);
    applyStimulus(PUSH, 8'd3);
    checkOutput("push3_full", 32'(bus.full), 32'd0);
    applyStimulus(PUSH, 8'd4);
    checkOutput("push4_full", 32'(bus.full), 32'd1);
    applyStimulus(PUSH, 8'd5);
    checkOutput("push5_err", 32'(bus.err), 32'd1);
    checkOutput("push5_outvalid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("err_one_cycle", 32'(bus.err), 32'd0);
    for (int i = 4; i >= 1; i--) begin
      applyStimulus(POP, 8'h00);
      checkOutput("pop_data", 32'(bus.output_data), 32'(i));
      checkOutput("pop_outvalid", 32'(bus.out_valid), 32'd1);
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);
    applyStimulus(POP, 8'h00);
    checkOutput("underflow_err", 32'(bus.err), 32'd1);
    checkOutput("underflow_out", 32'(bus.output_data), 32'd1);
    checkOutput("underflow_outvalid", 32'(bus.out_valid), 32'd0);

    // ADD and SUB, with and without signed overflow.
    applyStimulus(PUSH, 8'h01); applyStimulus(PUSH, 8'hFE); applyStimulus(ADD, 8'h00);
    checkOutput("add1_res", 32'(bus.output_data), 32'hFF);
    checkOutput("add1_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("add1_outvalid", 32'(bus.out_valid), 32'd1);
    applyStimulus(POP, 8'h00);
    checkOutput("add1_pop", 32'(bus.output_data), 32'hFF);
    applyStimulus(PUSH, 8'h7F); applyStimulus(PUSH, 8'h01); applyStimulus(ADD, 8'h00);
    checkOutput("add2_res", 32'(bus.output_data), 32'h80);
    checkOutput("add2_ovf", 32'(bus.overflow), 32'd1);
    applyStimulus(POP, 8'h00);
    applyStimulus(PUSH, 8'hFD); applyStimulus(PUSH, 8'h04); applyStimulus(SUB, 8'h00);
    checkOutput("sub1_res", 32'(bus.output_data), 32'hF9);
    checkOutput("sub1_ovf", 32'(bus.overflow), 32'd0);
    applyStimulus(POP, 8'h00);
    applyStimulus(PUSH, 8'h80); applyStimulus(PUSH, 8'h01); applyStimulus(SUB, 8'h00);
    checkOutput("sub2_res", 32'(bus.output_data), 32'h7F);
    checkOutput("sub2_ovf", 32'(bus.overflow), 32'd1);
    applyStimulus(POP, 8'h00);
    checkOutput("sub2_empty", 32'(bus.empty), 32'd1);

    // MUL: op_ready low for exactly WIDTH cycles, result in the cycle it rises.
    applyStimulus(PUSH, 8'hFD); applyStimulus(PUSH, 8'h04); applyStimulus(MUL, 8'h00);
    busyCycles = 0;
    while (!bus.op_ready && busyCycles < 20) begin
      busyCycles++;
      @(posedge clk); #1;
    end
    checkOutput("mul1_busy_cycles", 32'(busyCycles), 32'd8);
    checkOutput("mul1_outvalid", 32'(bus.out_valid), 32'd1);
    checkOutput("mul1_res", 32'(bus.output_data), 32'hF4);
    checkOutput("mul1_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("mul1_empty", 32'(bus.empty), 32'd0);
    applyStimulus(POP, 8'h00);
    checkOutput("mul1_pop", 32'(bus.output_data), 32'hF4);
    checkOutput("mul1_count1", 32'(bus.empty), 32'd1);

    // MUL with a POP held valid throughout MUL_RUN.
    applyStimulus(PUSH, 8'h81); applyStimulus(PUSH, 8'hFE); applyStimulus(MUL, 8'h00);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.opcode = POP;
    busyCycles = 0;
    while (!bus.out_valid && busyCycles < 20) begin
      @(posedge clk); #1;
      busyCycles++;
    end
    checkOutput("mul2_latency", 32'(busyCycles), 32'd8);
    checkOutput("mul2_res", 32'(bus.output_data), 32'hFE);
    checkOutput("mul2_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("mul2_held_not_taken", 32'(bus.empty), 32'd0);
    checkOutput("mul2_ready", 32'(bus.op_ready), 32'd1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    checkOutput("held_pop_outvalid", 32'(bus.out_valid), 32'd1);
    checkOutput("held_pop_data", 32'(bus.output_data), 32'hFE);
    checkOutput("held_pop_empty", 32'(bus.empty), 32'd1);
    checkOutput("pop_keeps_ovf", 32'(bus.overflow), 32'd1);

    // SWAP and DUP.
    applyStimulus(PUSH, 8'd5); applyStimulus(PUSH, 8'd9); applyStimulus(SWAP, 8'h00);
    applyStimulus(POP, 8'h00);
    checkOutput("swap_pop1", 32'(bus.output_data), 32'd5);
    applyStimulus(POP, 8'h00);
    checkOutput("swap_pop2", 32'(bus.output_data), 32'd9);
    applyStimulus(PUSH, 8'd7); applyStimulus(DUP, 8'h00);
    applyStimulus(POP, 8'h00);
    checkOutput("dup_pop1", 32'(bus.output_data), 32'd7);
    checkOutput("dup_count2", 32'(bus.empty), 32'd0);
    applyStimulus(POP, 8'h00);
    checkOutput("dup_pop2", 32'(bus.output_data), 32'd7);
    checkOutput("dup_empty", 32'(bus.empty), 32'd1);
    applyStimulus(DUP, 8'h00);
    checkOutput("dup_empty_err", 32'(bus.err), 32'd1);

    // Binary op with a single entry is rejected and leaves everything intact.
    applyStimulus(PUSH, 8'h33); applyStimulus(ADD, 8'h00);
    checkOutput("add_short_err", 32'(bus.err), 32'd1);
    checkOutput("add_short_out", 32'(bus.output_data), 32'd7);
    checkOutput("add_short_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("add_short_outvalid", 32'(bus.out_valid), 32'd0);
    applyStimulus(POP, 8'h00);
    checkOutput("add_short_entry", 32'(bus.output_data), 32'h33);
    checkOutput("add_short_empty", 32'(bus.empty), 32'd1);

    // Reset asserted in the middle of a multiply.
    applyStimulus(PUSH, 8'd2); applyStimulus(PUSH, 8'd3); applyStimulus(MUL, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("pre_rst_busy", 32'(bus.op_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_empty", 32'(bus.empty), 32'd1);
    checkOutput("midrst_ready", 32'(bus.op_ready), 32'd1);
    checkOutput("midrst_out", 32'(bus.output_data), 32'h0);
    checkOutput("midrst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_rst_out", 32'(bus.output_data), 32'h0);
    checkOutput("post_rst_empty", 32'(bus.empty), 32'd1);
    applyStimulus(PUSH, 8'd6); applyStimulus(POP, 8'h00);
    checkOutput("post_rst_pop", 32'(bus.output_data), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    failCount++;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
